// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader_pkg : state encoding and constants shared by the IMEM loader |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package imem_loader_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HDR0   = 3'd1;
   localparam logic [2:0] ST_HDR1   = 3'd2;
   localparam logic [2:0] ST_LOAD   = 3'd3;
   localparam logic [2:0] ST_VERIFY = 3'd4;
   localparam logic [2:0] ST_RUN    = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   localparam int MAX_WORDS_DEFAULT = 128;
   localparam int BYTES_PER_WORD    = 4;

   function automatic logic hdr_count_ok(input logic [15:0] cnt, input int max_words);
      return (cnt != 16'd0) && (int'(cnt) <= max_words);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_word_packer : assembles LSB-first bytes into 32-bit words           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        arst_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] asm_q, asm_d;
   logic        word_valid_q, word_valid_d;
   logic [31:0] word_q, word_d;

   assign last_byte  = byte_valid & ~clear & (idx_q == LAST_IDX);
   assign word_valid = word_valid_q;
   assign word       = word_q;

   // The output word register is separate so the next word can start assembling during the write cycle.
   always_comb begin
      idx_d        = idx_q;
      asm_d        = asm_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (clear) begin
         idx_d = 2'd0;
         asm_d = 24'd0;
      end else if (byte_valid) begin
         case (idx_q)
            2'd0:    asm_d[7:0]   = byte_data;
            2'd1:    asm_d[15:8]  = byte_data;
            2'd2:    asm_d[23:16] = byte_data;
            default: begin
               word_d       = {byte_data, asm_q};
               word_valid_d = 1'b1;
            end
         endcase
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         idx_q        <= 2'd0;
         asm_q        <= 24'd0;
         word_q       <= 32'd0;
         word_valid_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         asm_q        <= asm_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader : boot loader streaming a program into IMEM, then runs cpu   |
// | Optional read-back verify: define IMEM_LOADER_VERIFY_EN. Revision 1.0    |
// +--------------------------------------------------------------------------+
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MAX_WORDS = MAX_WORDS_DEFAULT
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   output logic [ADDR_W-1:0] addr_ext,
   output logic              wen_ext,
   output logic              ren_ext,
   output logic [31:0]       wdata_ext,
   input  logic [31:0]       rdata_ext,
   output logic              cpu_enable,
   output logic              busy,
   output logic              done,
   output logic              error
);

   logic [2:0]        state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       word_idx_q, word_idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic        hs, load_open, start_ok;
   logic        pk_last, pk_word_valid;
   logic [31:0] pk_word;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] idx);
      return BASE_ADDR + ADDR_W'({idx, 2'b00});
   endfunction

   // Ready drops once every word byte is in, so the final write cycle cannot start a stray word.
   assign load_open = (state_q == ST_LOAD) && (word_idx_q != count_q);
   assign s_ready   = (state_q == ST_HDR0) || (state_q == ST_HDR1) || load_open;
   assign hs        = s_valid & s_ready;
   assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

   imem_word_packer u_packer (
      .clk        (clk),
      .arst_n     (arst_n),
      .clear      (abort | start_ok),
      .byte_valid (hs & (state_q == ST_LOAD) & ~abort),
      .byte_data  (s_data),
      .last_byte  (pk_last),
      .word_valid (pk_word_valid),
      .word       (pk_word)
   );

`ifdef IMEM_LOADER_VERIFY_EN
   logic [15:0] vidx_q, vidx_d;
   logic        ren_q, ren_d;
   logic [31:0] wr_sum_q, wr_sum_d;
   logic [31:0] rd_sum_q, rd_sum_d;
   assign ren_ext = ren_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^rdata_ext;
   assign ren_ext      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      addr_d     = addr_q;
`ifdef IMEM_LOADER_VERIFY_EN
      vidx_d   = vidx_q;
      ren_d    = 1'b0;
      wr_sum_d = wr_sum_q;
      rd_sum_d = rd_sum_q;
`endif
      if (abort) begin
         state_d = ST_IDLE;
      end else if (start_ok) begin
         state_d    = ST_HDR0;
         count_d    = 16'd0;
         word_idx_d = 16'd0;
`ifdef IMEM_LOADER_VERIFY_EN
         wr_sum_d = 32'd0;
`endif
      end else begin
         case (state_q)
            ST_HDR0: if (hs) begin
               count_d[7:0] = s_data;
               state_d      = ST_HDR1;
            end
            ST_HDR1: if (hs) begin
               count_d[15:8] = s_data;
               state_d = hdr_count_ok({s_data, count_q[7:0]}, MAX_WORDS) ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
               if (pk_last) begin
                  addr_d     = word_addr(word_idx_q);
                  word_idx_d = word_idx_q + 16'd1;
               end
               if (pk_word_valid) begin
`ifdef IMEM_LOADER_VERIFY_EN
                  wr_sum_d = wr_sum_q ^ pk_word;
`endif
                  if (word_idx_q == count_q) begin
`ifdef IMEM_LOADER_VERIFY_EN
                     state_d  = ST_VERIFY;
                     vidx_d   = 16'd0;
                     ren_d    = 1'b1;
                     addr_d   = word_addr(16'd0);
                     rd_sum_d = 32'd0;
`else
                     state_d = ST_RUN;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            // Alternate read-issue and sample cycles; the checksum is judged after the last sample.
            ST_VERIFY: if (!ren_q) begin
               rd_sum_d = rd_sum_q ^ rdata_ext;
               if (vidx_q + 16'd1 == count_q) begin
                  state_d = (rd_sum_d == wr_sum_q) ? ST_RUN : ST_ERR;
               end else begin
                  vidx_d = vidx_q + 16'd1;
                  ren_d  = 1'b1;
                  addr_d = word_addr(vidx_q + 16'd1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= 16'd0;
         word_idx_q <= 16'd0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         addr_q     <= addr_d;
      end
   end

`ifdef IMEM_LOADER_VERIFY_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         vidx_q   <= 16'd0;
         ren_q    <= 1'b0;
         wr_sum_q <= 32'd0;
         rd_sum_q <= 32'd0;
      end else begin
         vidx_q   <= vidx_d;
         ren_q    <= ren_d;
         wr_sum_q <= wr_sum_d;
         rd_sum_q <= rd_sum_d;
      end
   end
`endif

   assign addr_ext   = addr_q;
   assign wen_ext    = pk_word_valid;
   assign wdata_ext  = pk_word;
   assign cpu_enable = (state_q == ST_RUN);
   assign done       = (state_q == ST_RUN);
   assign error      = (state_q == ST_ERR);
   assign busy       = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                       (state_q == ST_LOAD) || (state_q == ST_VERIFY);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_loader : randomized self-checking bench for imem_loader          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

   localparam int          ADDR_W = 64;
   localparam logic [63:0] BASE   = 64'h0;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic [31:0] rdata_ext = 32'h0;
   logic        s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
   logic [63:0] addr_ext;
   logic [31:0] wdata_ext;

   int checks = 0;
   int failures = 0;
   int wen_cnt = 0;
   int ren_cnt = 0;
   int gapmax = 0;
   bit corrupt = 1'b0;

   logic [63:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [63:0] log_addr[$];
   logic [31:0] log_data[$];
   logic [31:0] prog [0:255];
   logic [31:0] mem  [0:255];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(128)) dut (
      .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
      .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // IMEM model: registered read, optional single-bit corruption of word 1 on read-back.
   always @(posedge clk) begin
      if (wen_ext) mem[addr_ext[9:2]] <= wdata_ext;
      if (ren_ext) rdata_ext <= mem[addr_ext[9:2]] ^ ((corrupt && addr_ext[9:2] == 8'd1) ? 32'h0000_0100 : 32'h0);
   end

   // Every write must be the next word the stream model expects.
   always @(negedge clk) begin : compare
      logic [63:0] ea;
      logic [31:0] ed;
      if (arst_n) begin
         if (wen_ext) begin
            wen_cnt++;
            log_addr.push_back(addr_ext);
            log_data.push_back(wdata_ext);
            if (exp_addr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got addr %0h data %0h, required no write", addr_ext, wdata_ext);
            end else begin
               ea = exp_addr.pop_front();
               ed = exp_data.pop_front();
               chk("write_addr", addr_ext, ea);
               chk("write_data", {32'h0, wdata_ext}, {32'h0, ed});
            end
         end
         if (ren_ext) ren_cnt++;
         chk("wen_ren_exclusive", {63'h0, wen_ext & ren_ext}, 64'h0);
         chk("done_tracks_enable", {63'h0, done}, {63'h0, cpu_enable});
         chk("busy_excl_enable", {63'h0, busy & cpu_enable}, 64'h0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      int gap;
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      s_valid = 1'b0;
      repeat (gap) tick();
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (!s_ready && n < 64) begin
         tick();
         n++;
      end
      if (!s_ready) begin
         checks++;
         failures++;
         $display("FAIL byte_timeout: got s_ready=0 for %0d cycles, required 1", n);
         s_valid = 1'b0;
         return;
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic send_word(input int idx, input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
      exp_addr.push_back(BASE + 64'(4 * idx));
      exp_data.push_back(w);
   endtask

   task automatic send_hdr(input int n);
      logic [15:0] c;
      c = 16'(n);
      send_byte(c[7:0]);
      send_byte(c[15:8]);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic load_prog(input int n);
      do_start();
      send_hdr(n);
      for (int i = 0; i < n; i++) send_word(i, prog[i]);
   endtask

   // Called in the final write cycle; checks the loader reaches RUN on schedule.
   task automatic expect_run(input string tag, input int n);
`ifdef IMEM_LOADER_VERIFY_EN
      int r0;
      r0 = ren_cnt;
      repeat (2 * n) tick();
      chk({tag, "_enable_in_verify"}, {63'h0, cpu_enable}, 64'h0);
      tick();
      chk({tag, "_ren_pulses"}, 64'(ren_cnt - r0), 64'(n));
`else
      tick();
`endif
      chk({tag, "_cpu_enable"}, {63'h0, cpu_enable}, 64'h1);
      chk({tag, "_done"}, {63'h0, done}, 64'h1);
      chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog: got no finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wc, n;
      logic any_ready;

      #2;
      chk("rst_outputs", {addr_ext, 25'h0, s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error}, 64'h0);
      chk("rst_wdata", {32'h0, wdata_ext}, 64'h0);
      repeat (3) @(posedge clk);
      #2 arst_n = 1'b1;
      tick();
      chk("idle_ready", {63'h0, s_ready}, 64'h0);
      chk("idle_busy", {63'h0, busy}, 64'h0);

      // Two-word program, continuous stream.
      prog[0] = 32'h0000_0013;
      prog[1] = 32'h0010_0093;
      load_prog(2);
      chk("s1_last_wen", {63'h0, wen_ext}, 64'h1);
      chk("s1_enable_at_last_write", {63'h0, cpu_enable}, 64'h0);
      expect_run("s1", 2);
      chk("s1_write_count", 64'(wen_cnt), 64'd2);
      chk("s1_addr0", log_addr[0], 64'h0);
      chk("s1_data0", {32'h0, log_data[0]}, 64'h13);
      chk("s1_addr1", log_addr[1], 64'h4);
      chk("s1_data1", {32'h0, log_data[1]}, 64'h0010_0093);
      repeat (5) tick();
      chk("s1_run_held", {62'h0, cpu_enable, s_ready}, 64'h2);

      // start in RUN is ignored; abort returns to IDLE.
      do_start();
      chk("run_start_ignored", {62'h0, cpu_enable, busy}, 64'h2);
      do_abort();
      chk("abort_from_run", {60'h0, cpu_enable, done, busy, error}, 64'h0);

      // Zero-length header.
      wc = wen_cnt;
      do_start();
      chk("hdr0_busy", {63'h0, busy}, 64'h1);
      send_hdr(0);
      chk("zero_hdr_error", {60'h0, error, s_ready, cpu_enable, busy}, 64'h8);
      do_start();
      chk("restart_clears_error", {62'h0, error, busy}, 64'h1);
      prog[0] = $urandom;
      send_hdr(1);
      send_word(0, prog[0]);
      expect_run("restart", 1);
      chk("restart_writes", 64'(wen_cnt - wc), 64'd1);

      // Oversize header: 129 words.
      do_abort();
      wc = wen_cnt;
      do_start();
      send_hdr(129);
      chk("over_hdr_error", {62'h0, error, s_ready}, 64'h2);
      s_valid = 1'b1;
      any_ready = 1'b0;
      repeat (5) begin
         tick();
         any_ready |= s_ready;
      end
      s_valid = 1'b0;
      chk("over_hdr_ready_low", {63'h0, any_ready}, 64'h0);
      chk("over_hdr_no_write", 64'(wen_cnt - wc), 64'd0);

      // Exactly MAX_WORDS is accepted.
      do_abort();
      wc = wen_cnt;
      for (int i = 0; i < 128; i++) prog[i] = $urandom;
      load_prog(128);
      expect_run("max_words", 128);
      chk("max_words_writes", 64'(wen_cnt - wc), 64'd128);

      // Same 4-word program without and with random valid gaps.
      for (int i = 0; i < 4; i++) prog[i] = $urandom;
      for (int pass = 0; pass < 2; pass++) begin
         do_abort();
         gapmax = pass * 3;
         wc = wen_cnt;
         load_prog(4);
         expect_run("four_word", 4);
         chk("four_word_writes", 64'(wen_cnt - wc), 64'd4);
      end
      gapmax = 0;

      // Abort with start after 6 payload bytes.
      do_abort();
      wc = wen_cnt;
      do_start();
      send_hdr(4);
      send_word(0, 32'hA5A5_1234);
      send_byte(8'h11);
      send_byte(8'h22);
      start = 1'b1;
      abort = 1'b1;
      s_valid = 1'b1;
      s_data = 8'h33;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_state", {59'h0, busy, s_ready, error, cpu_enable, done}, 64'h0);
      repeat (10) tick();
      s_valid = 1'b0;
      chk("abort_one_write", 64'(wen_cnt - wc), 64'd1);

      // Randomized programs.
      for (int it = 0; it < 6; it++) begin
         n = int'($urandom_range(1, 9));
         gapmax = int'($urandom_range(0, 2));
         for (int i = 0; i < n; i++) prog[i] = $urandom;
         do_abort();
         wc = wen_cnt;
         load_prog(n);
         expect_run("rand", n);
         chk("rand_writes", 64'(wen_cnt - wc), 64'(n));
      end
      gapmax = 0;

`ifdef IMEM_LOADER_VERIFY_EN
      // Corrupted read-back of word 1.
      do_abort();
      for (int i = 0; i < 3; i++) prog[i] = $urandom;
      corrupt = 1'b1;
      load_prog(3);
      repeat (7) tick();
      chk("verify_bad_error", {62'h0, error, cpu_enable}, 64'h2);
      corrupt = 1'b0;
      do_abort();
      load_prog(3);
      expect_run("verify_good", 3);
`endif

      chk("exp_queue_drained", 64'(exp_addr.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
